qft_mac_seq_ctrl: RTL and testbench

//  Sequencer for the multi-lane QFT datapath. Drives the complex-multiply/accumulate lanes over a

---
 rtl/qft_mac_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_qft_mac_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qft_mac_seq_ctrl.sv
// Sequencer for the multi-lane QFT MAC datapath and the ABS magnitude pass.
// Optional abort support is enabled by defining QFT_SEQ_ABORT_EN.
module qft_mac_seq_ctrl #(
    parameter int N        = 8,
    parameter int LANES    = 2,
    parameter int MULT_LAT = 1,
    localparam int CW      = $clog2(N),
    localparam int G       = N / LANES,
    localparam int GW      = (G > 1) ? $clog2(G) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          strt_qft,
    input  logic          strt_abs,
`ifdef QFT_SEQ_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    output logic          w_en_mult,
    output logic          w_en_acc,
    output logic          acc_clr,
    output logic          w_en_wb,
    output logic          w_en_abs,
    output logic [CW-1:0] col_idx,
    output logic [GW-1:0] grp_idx,
    output logic          busy,
    output logic          done
);

    localparam int WW = (MULT_LAT > 2) ? $clog2(MULT_LAT - 1) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(N - 1);
    localparam logic [GW-1:0] GRP_LAST  = GW'(G - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MULT_LAT - 2);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_MULT = 3'd2,
        S_WAIT = 3'd3,
        S_ACC  = 3'd4,
        S_WB   = 3'd5,
        S_ABS  = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [GW-1:0] grp_q, grp_d;
    logic [WW-1:0] wait_q, wait_d;

`ifdef QFT_SEQ_ABORT_EN
    logic aborted_q, aborted_d;
    logic abortable;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            col_q   <= '0;
            grp_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            grp_q   <= grp_d;
            wait_q  <= wait_d;
        end
    end

`ifdef QFT_SEQ_ABORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end

    // DONE is excluded: the sweep has already completed there.
    assign abortable = (state_q == S_MULT) || (state_q == S_WAIT) ||
                       (state_q == S_ACC)  || (state_q == S_WB)   ||
                       (state_q == S_ABS);
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        grp_d   = grp_q;
        wait_d  = wait_q;
`ifdef QFT_SEQ_ABORT_EN
        aborted_d = 1'b0;
`endif
        case (state_q)
            S_INIT: begin
                state_d = S_IDLE;
            end
            S_IDLE: begin
                col_d  = '0;
                grp_d  = '0;
                wait_d = '0;
                if (strt_qft) begin
                    state_d = S_MULT;
                end else if (strt_abs) begin
                    state_d = S_ABS;
                end
            end
            S_MULT: begin
                wait_d = '0;
                if (MULT_LAT > 1) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_ACC;
                end
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = S_ACC;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_ACC: begin
                if (col_q < COL_LAST) begin
                    col_d   = col_q + 1'b1;
                    state_d = S_MULT;
                end else begin
                    col_d   = '0;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (grp_q < GRP_LAST) begin
                    grp_d   = grp_q + 1'b1;
                    state_d = S_MULT;
                end else begin
                    grp_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_ABS: begin
                if (grp_q < GRP_LAST) begin
                    grp_d = grp_q + 1'b1;
                end else begin
                    grp_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                col_d   = '0;
                grp_d   = '0;
                wait_d  = '0;
            end
        endcase
`ifdef QFT_SEQ_ABORT_EN
        if (abort && abortable) begin
            state_d   = S_IDLE;
            col_d     = '0;
            grp_d     = '0;
            wait_d    = '0;
            aborted_d = 1'b1;
        end
`endif
    end

    assign w_en_mult = (state_q == S_MULT);
    assign acc_clr   = (state_q == S_MULT) && (col_q == '0);
    assign w_en_acc  = (state_q == S_ACC);
    assign w_en_wb   = (state_q == S_WB);
    assign w_en_abs  = (state_q == S_ABS);
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_INIT) && (state_q != S_IDLE);
    assign col_idx   = col_q;
    assign grp_idx   = grp_q;

`ifdef QFT_SEQ_ABORT_EN
    assign aborted = aborted_q;
`endif

endmodule

// File: tb/tb_qft_mac_seq_ctrl.sv
// Scoreboard bench for qft_mac_seq_ctrl: main instance (N=8,LANES=2,LAT=3)
// plus a small instance (N=2,LANES=1,LAT=1).
module tb_qft_mac_seq_ctrl;

    typedef struct packed {
        logic       mult;
        logic       acc;
        logic       clr;
        logic       wb;
        logic       abs;
        logic       dn;
        logic [2:0] col;
        logic [1:0] grp;
    } ev_t;

    localparam ev_t SENT = '1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic strt_qft = 1'b0;
    logic strt_abs = 1'b0;
    logic strt2 = 1'b0;

    logic       mult, acc, clr, wb, abs_o, busy, dn;
    logic [2:0] col;
    logic [1:0] grp;

    logic       mult2, acc2, clr2, wb2, abs2, busy2, dn2;
    logic [0:0] col2;
    logic [0:0] grp2;

`ifdef QFT_SEQ_ABORT_EN
    logic abort = 1'b0;
    logic aborted;
    logic abort2 = 1'b0;
    logic aborted2;
`endif

    int total = 0;
    int bad = 0;
    int bc = 0;
    int bc2 = 0;
    ev_t q1[$];
    ev_t q2[$];

    always #5 clk = ~clk;

    qft_mac_seq_ctrl #(.N(8), .LANES(2), .MULT_LAT(3)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .strt_qft(strt_qft), .strt_abs(strt_abs),
`ifdef QFT_SEQ_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .w_en_mult(mult), .w_en_acc(acc), .acc_clr(clr),
        .w_en_wb(wb), .w_en_abs(abs_o),
        .col_idx(col), .grp_idx(grp),
        .busy(busy), .done(dn)
    );

    qft_mac_seq_ctrl #(.N(2), .LANES(1), .MULT_LAT(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .strt_qft(strt2), .strt_abs(1'b0),
`ifdef QFT_SEQ_ABORT_EN
        .abort(abort2), .aborted(aborted2),
`endif
        .w_en_mult(mult2), .w_en_acc(acc2), .acc_clr(clr2),
        .w_en_wb(wb2), .w_en_abs(abs2),
        .col_idx(col2), .grp_idx(grp2),
        .busy(busy2), .done(dn2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic ev_t mk(input logic m, a, c, w, ab, d,
                               input int cl, input int g);
        ev_t e;
        e.mult = m;
        e.acc  = a;
        e.clr  = c;
        e.wb   = w;
        e.abs  = ab;
        e.dn   = d;
        e.col  = 3'(cl);
        e.grp  = 2'(g);
        return e;
    endfunction

    task automatic push(input int sel, input ev_t e);
        if (sel == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic gen_qft(input int sel, input int n, input int lanes,
                           input int lat);
        for (int g = 0; g < n / lanes; g++) begin
            for (int c = 0; c < n; c++) begin
                push(sel, mk(1, 0, c == 0, 0, 0, 0, c, g));
                for (int w = 0; w < lat - 1; w++)
                    push(sel, mk(0, 0, 0, 0, 0, 0, c, g));
                push(sel, mk(0, 1, 0, 0, 0, 0, c, g));
            end
            push(sel, mk(0, 0, 0, 1, 0, 0, 0, g));
        end
        push(sel, mk(0, 0, 0, 0, 0, 1, 0, 0));
    endtask

    task automatic gen_abs(input int groups);
        for (int g = 0; g < groups; g++)
            push(1, mk(0, 0, 0, 0, 1, 0, 0, g));
        push(1, mk(0, 0, 0, 0, 0, 1, 0, 0));
    endtask

    function automatic ev_t obs1();
        return {mult, acc, clr, wb, abs_o, dn, col, grp};
    endfunction

    function automatic ev_t obs2();
        return {mult2, acc2, clr2, wb2, abs2, dn2, 2'b00, col2, 1'b0, grp2};
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (busy) begin
                bc++;
                chk("seq1", obs1(), (q1.size() != 0) ? q1.pop_front() : SENT);
            end else begin
                chk("idle1", obs1(), '0);
            end
            if (busy2) begin
                bc2++;
                chk("seq2", obs2(), (q2.size() != 0) ? q2.pop_front() : SENT);
            end
        end
    end

    task automatic start(input logic sq, input logic sa, input logic s2);
        @(posedge clk);
        #1;
        strt_qft = sq;
        strt_abs = sa;
        strt2 = s2;
        @(posedge clk);
        #1;
        strt_qft = 1'b0;
        strt_abs = 1'b0;
        strt2 = 1'b0;
    endtask

    task automatic drain(input int sel, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if ((sel == 1 ? q1.size() : q2.size()) == 0) break;
        end
        chk("drain", sel == 1 ? q1.size() : q2.size(), 0);
        @(negedge clk);
        #1;
        chk("idle_after", sel == 1 ? busy : busy2, 0);
    endtask

    initial begin
        // Reset state and start ignored while in INIT
        strt_qft = 1'b1;
        #12;
        chk("rst_outs", {obs1(), busy}, '0);
        chk("rst_outs2", {obs2(), busy2}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        strt_qft = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("init_ign", busy, 0);

        // Full QFT sweep
        bc = 0;
        gen_qft(1, 8, 2, 3);
        start(1, 0, 0);
        drain(1, 400);
        chk("qft_busy", bc, 133);

        // ABS pass
        bc = 0;
        gen_abs(4);
        start(0, 1, 0);
        drain(1, 50);
        chk("abs_busy", bc, 5);

        // Simultaneous starts: QFT wins; ABS start mid-run dropped
        bc = 0;
        gen_qft(1, 8, 2, 3);
        start(1, 1, 0);
        repeat (10) @(posedge clk);
        #1;
        strt_abs = 1'b1;
        @(posedge clk);
        #1;
        strt_abs = 1'b0;
        drain(1, 400);
        chk("both_busy", bc, 133);

        // Minimal configuration on second instance
        bc2 = 0;
        gen_qft(2, 2, 1, 1);
        start(0, 0, 1);
        drain(2, 50);
        chk("small_busy", bc2, 11);

        // Async reset during group 2, then clean restart
        gen_qft(1, 8, 2, 3);
        start(1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (grp == 2'd2) break;
        end
        chk("reach_g2", grp, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid", {obs1(), busy}, '0);
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bc = 0;
        gen_qft(1, 8, 2, 3);
        start(1, 0, 0);
        drain(1, 400);
        chk("restart_busy", bc, 133);

`ifdef QFT_SEQ_ABORT_EN
        gen_qft(1, 8, 2, 3);
        start(1, 0, 0);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        q1.delete();
        chk("ab_pulse", aborted, 1);
        chk("ab_idle", {busy, dn}, 0);
        @(negedge clk);
        #1;
        chk("ab_once", aborted, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
